// File: rtl/program_counter_ras.sv
// Fetch-head program counter with a circular return-address stack.
// Supports hold/step/jump/branch/call/return, stall and sync active-low reset.
module program_counter_ras #(
  parameter int WIDTH = 32,
  parameter int STEP = 4,
  parameter int OFFSET_SHIFT = 2,
  parameter int RAS_DEPTH = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic clock,
  input  logic reset,
  input  logic stall,
  input  logic [2:0] PS,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] PC,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic ras_overflow,
  output logic ras_underflow
);

  localparam int CW = $clog2(RAS_DEPTH+1);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);
  localparam logic [PW-1:0] LAST = PW'(RAS_DEPTH-1);

  logic [WIDTH-1:0] stack [RAS_DEPTH];
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc4, rel;
  logic [PW-1:0] top_q, top_d;
  logic [PW-1:0] top_inc, top_dec;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;
  logic push;

  always_comb begin
    pc4 = pc_q + WIDTH'(STEP);
    rel = pc4 + (in << OFFSET_SHIFT);
    top_inc = (top_q == LAST) ? '0 : top_q + PW'(1);
    top_dec = (top_q == '0) ? LAST : top_q - PW'(1);
  end

  always_comb begin
    pc_d = pc_q;
    top_d = top_q;
    cnt_d = cnt_q;
    push = 1'b0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (!stall) begin
      unique case (PS)
        3'b001: pc_d = pc4;
        3'b010: pc_d = in;
        3'b011: pc_d = rel;
        3'b100: begin
          push = 1'b1;
          pc_d = in;
        end
        3'b101: begin
          push = 1'b1;
          pc_d = rel;
        end
        3'b110: begin
          if (cnt_q != '0) begin
            pc_d = stack[top_q];
            top_d = top_dec;
            cnt_d = cnt_q - CW'(1);
          end else begin
            pc_d = pc4;
            unf_d = 1'b1;
          end
        end
        default: pc_d = pc_q;
      endcase
    end
    // A full stack overwrites its oldest slot, which is the one after top.
    if (push) begin
      top_d = top_inc;
      if (cnt_q == FULL) ovf_d = 1'b1;
      else cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q <= RESET_VECTOR;
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset && push) stack[top_inc] <= pc4;
  end

  assign PC = pc_q;
  assign ras_count = cnt_q;
  assign ras_overflow = ovf_q;
  assign ras_underflow = unf_q;

endmodule

// File: tb/tb_program_counter_ras.sv
// Randomised + directed bench for program_counter_ras against a queue model.
// Model keeps the RAS as a bounded LIFO queue of return addresses.
module tb_program_counter_ras;

  localparam logic [31:0] RV = 32'h100;

  logic clock;
  logic reset;
  logic stall;
  logic [2:0] PS;
  logic [31:0] in;
  logic [31:0] PC;
  logic [3:0] ras_count;
  logic ras_overflow;
  logic ras_underflow;

  int n_chk;
  int n_err;

  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  logic m_ovf;
  logic m_unf;

  program_counter_ras #(
    .WIDTH(32),
    .STEP(4),
    .OFFSET_SHIFT(2),
    .RAS_DEPTH(8),
    .RESET_VECTOR(RV)
  ) dut (
    .clock(clock),
    .reset(reset),
    .stall(stall),
    .PS(PS),
    .in(in),
    .PC(PC),
    .ras_count(ras_count),
    .ras_overflow(ras_overflow),
    .ras_underflow(ras_underflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic m_push(input logic [31:0] a);
    m_q.push_back(a);
    if (m_q.size() > 8) begin
      void'(m_q.pop_front());
      m_ovf = 1'b1;
    end
  endtask

  task automatic model(input logic r, input logic s,
                       input logic [2:0] p,
                       input logic [31:0] i);
    logic [31:0] pc4;
    logic [31:0] rl;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    if (!r) begin
      m_pc = RV;
      m_q.delete();
    end else if (!s) begin
      pc4 = m_pc + 32'd4;
      rl = pc4 + (i << 2);
      case (p)
        3'd1: m_pc = pc4;
        3'd2: m_pc = i;
        3'd3: m_pc = rl;
        3'd4: begin m_push(pc4); m_pc = i; end
        3'd5: begin m_push(pc4); m_pc = rl; end
        3'd6: begin
          if (m_q.size() > 0) m_pc = m_q.pop_back();
          else begin m_pc = pc4; m_unf = 1'b1; end
        end
        default: m_pc = m_pc;
      endcase
    end
  endtask

  task automatic cyc(input logic r, input logic s,
                     input logic [2:0] p,
                     input logic [31:0] i);
    reset = r;
    stall = s;
    PS = p;
    in = i;
    @(posedge clock);
    model(r, s, p, i);
    #1;
    chk("pc", PC, m_pc);
    chk("count", 32'(ras_count), 32'(m_q.size()));
    chk("ovf", 32'(ras_overflow), 32'(m_ovf));
    chk("unf", 32'(ras_underflow), 32'(m_unf));
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    clock = 1'b0;
    reset = 1'b0;
    stall = 1'b0;
    PS = 3'd0;
    in = '0;
    m_pc = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #1;

    cyc(0, 0, 3'd1, 32'h0);
    cyc(0, 0, 3'd1, 32'h0);
    chk("t1_rst_pc", PC, 32'h100);
    repeat (3) cyc(1, 0, 3'd1, 32'h0);
    chk("t1_step_pc", PC, 32'h10C);

    cyc(1, 0, 3'd2, 32'h200);
    cyc(1, 0, 3'd3, 32'hFFFF_FFFE);
    chk("t2_branch", PC, 32'h1FC);
    cyc(1, 0, 3'd2, 32'h8000);
    chk("t2_jump", PC, 32'h8000);
    cyc(1, 0, 3'd2, 32'hFFFF_FFFC);
    cyc(1, 0, 3'd1, 32'h0);
    chk("t2_wrap", PC, 32'h0);

    cyc(1, 0, 3'd2, 32'h40);
    cyc(1, 0, 3'd4, 32'h400);
    cyc(1, 0, 3'd4, 32'h800);
    chk("t3_cnt2", 32'(ras_count), 32'd2);
    cyc(1, 0, 3'd6, 32'h0);
    chk("t3_ret1", PC, 32'h404);
    cyc(1, 0, 3'd6, 32'h0);
    chk("t3_ret2", PC, 32'h44);

    cyc(0, 0, 3'd0, 32'h0);
    cyc(1, 0, 3'd2, 32'h0);
    for (int k = 0; k < 9; k++) cyc(1, 0, 3'd4, PC + 32'd4);
    chk("t4_ovf", 32'(ras_overflow), 32'd1);
    chk("t4_cnt", 32'(ras_count), 32'd8);
    cyc(1, 0, 3'd6, 32'h0);
    chk("t4_ret_top", PC, 32'h24);
    for (int k = 0; k < 7; k++) cyc(1, 0, 3'd6, 32'h0);
    chk("t4_ret_last", PC, 32'h8);
    cyc(1, 0, 3'd6, 32'h0);
    chk("t4_unf", 32'(ras_underflow), 32'd1);

    cyc(1, 0, 3'd2, 32'h300);
    repeat (3) cyc(1, 1, 3'd4, 32'h900);
    chk("t5_stall", PC, 32'h300);
    cyc(1, 0, 3'd4, 32'h900);
    chk("t5_go", PC, 32'h900);

    cyc(1, 0, 3'd4, 32'h10);
    cyc(1, 0, 3'd4, 32'h20);
    cyc(0, 0, 3'd4, 32'h900);
    chk("t6_pc", PC, RV);
    chk("t6_cnt", 32'(ras_count), 32'd0);

    for (int k = 0; k < 3000; k++) begin
      logic r;
      logic s;
      logic [2:0] p;
      logic [31:0] i;
      r = ($urandom_range(0, 99) != 0);
      s = ($urandom_range(0, 7) == 0);
      p = 3'($urandom_range(0, 7));
      if (p == 3'd3 || p == 3'd5)
        i = 32'($signed($urandom_range(0, 63)) - 32);
      else
        i = $urandom;
      cyc(r, s, p, i);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_chk, n_err);
    $finish;
  end

endmodule
